// File: rtl/decode_unit.sv
`default_nettype none
// ============================================================================
// Module      : decode_unit
// Description : Dual-lane RV32I decoder. Each lane emits raw field slices, a
//               sign-extended immediate and an 8-bit control vector, both as a
//               combinational [0] copy and a one-cycle registered [1] copy.
// Revision    : 1.0 - initial release
// ============================================================================
module decode_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instr_A,
  input  logic [31:0] instr_B,
  output logic [6:0]  opcode_A,
  output logic [6:0]  opcode_B,
  output logic [4:0]  rd_A     [0:1],
  output logic [4:0]  rd_B     [0:1],
  output logic [2:0]  funct3_A [0:1],
  output logic [2:0]  funct3_B [0:1],
  output logic [4:0]  rs1_A    [0:1],
  output logic [4:0]  rs1_B    [0:1],
  output logic [4:0]  rs2_A    [0:1],
  output logic [4:0]  rs2_B    [0:1],
  output logic [6:0]  funct7_A [0:1],
  output logic [6:0]  funct7_B [0:1],
  output logic [31:0] imm_A    [0:1],
  output logic [31:0] imm_B    [0:1],
  output logic [7:0]  ctrls_A  [0:1],
  output logic [7:0]  ctrls_B  [0:1]
);

  // Opcodes; bits [1:0] are 2'b11 in every one, so a full 7-bit match also
  // covers the compressed-encoding (illegal) check.
  localparam logic [6:0] c_op_r      = 7'b0110011;
  localparam logic [6:0] c_op_i_alu  = 7'b0010011;
  localparam logic [6:0] c_op_load   = 7'b0000011;
  localparam logic [6:0] c_op_store  = 7'b0100011;
  localparam logic [6:0] c_op_branch = 7'b1100011;
  localparam logic [6:0] c_op_jal    = 7'b1101111;
  localparam logic [6:0] c_op_jalr   = 7'b1100111;
  localparam logic [6:0] c_op_lui    = 7'b0110111;
  localparam logic [6:0] c_op_auipc  = 7'b0010111;

  // Returns {imm[31:0], ctrls[7:0]}; unknown opcodes fall out as illegal.
  function automatic logic [39:0] decode_imm_ctrls(input logic [31:0] i);
    logic [31:0] imm;
    logic [7:0]  ctrls;
    imm   = '0;
    ctrls = 8'h80;
    case (i[6:0])
      c_op_r:      ctrls = 8'h01;
      c_op_i_alu:  begin ctrls = 8'h03; imm = {{20{i[31]}}, i[31:20]}; end
      c_op_load:   begin ctrls = 8'h17; imm = {{20{i[31]}}, i[31:20]}; end
      c_op_jalr:   begin ctrls = 8'h43; imm = {{20{i[31]}}, i[31:20]}; end
      c_op_store:  begin ctrls = 8'h0A; imm = {{20{i[31]}}, i[31:25], i[11:7]}; end
      c_op_branch: begin
        ctrls = 8'h20;
        imm   = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
      end
      c_op_lui,
      c_op_auipc:  begin ctrls = 8'h03; imm = {i[31:12], 12'b0}; end
      c_op_jal:    begin
        ctrls = 8'h41;
        imm   = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
      end
      default: begin
        ctrls = 8'h80;
        imm   = '0;
      end
    endcase
    return {imm, ctrls};
  endfunction

  // Per-lane bundle: [64:58] funct7, [57:53] rs2, [52:48] rs1,
  // [47:45] funct3, [44:40] rd, [39:8] imm, [7:0] ctrls.
  logic [31:0] w_instr  [0:1];
  logic [64:0] w_fields [0:1];
  logic [64:0] r_fields [0:1];

  assign w_instr[0] = instr_A;
  assign w_instr[1] = instr_B;

  for (genvar g = 0; g < 2; g++) begin : g_lane
    assign w_fields[g] = {w_instr[g][31:25], w_instr[g][24:20], w_instr[g][19:15],
                          w_instr[g][14:12], w_instr[g][11:7],
                          decode_imm_ctrls(w_instr[g])};

    // Issue-stage copy; reset clears it to an all-zero bubble at once.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_fields[g] <= '0;
      end else begin
        r_fields[g] <= w_fields[g];
      end
    end
  end

  assign opcode_A = instr_A[6:0];
  assign opcode_B = instr_B[6:0];

  for (genvar s = 0; s < 2; s++) begin : g_stage
    logic [64:0] w_a;
    logic [64:0] w_b;
    assign w_a = (s == 0) ? w_fields[0] : r_fields[0];
    assign w_b = (s == 0) ? w_fields[1] : r_fields[1];

    assign funct7_A[s] = w_a[64:58];
    assign rs2_A[s]    = w_a[57:53];
    assign rs1_A[s]    = w_a[52:48];
    assign funct3_A[s] = w_a[47:45];
    assign rd_A[s]     = w_a[44:40];
    assign imm_A[s]    = w_a[39:8];
    assign ctrls_A[s]  = w_a[7:0];

    assign funct7_B[s] = w_b[64:58];
    assign rs2_B[s]    = w_b[57:53];
    assign rs1_B[s]    = w_b[52:48];
    assign funct3_B[s] = w_b[47:45];
    assign rd_B[s]     = w_b[44:40];
    assign imm_B[s]    = w_b[39:8];
    assign ctrls_B[s]  = w_b[7:0];
  end

endmodule
`default_nettype wire

// File: tb/tb_decode_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_decode_unit
// Description : Self-checking bench for decode_unit: directed test-plan
//               vectors plus randomized instructions against a field/format
//               model, with a mid-cycle asynchronous reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_decode_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] instr_A = '0;
  logic [31:0] instr_B = '0;
  logic [6:0]  opcode_A, opcode_B;
  logic [4:0]  rd_A [0:1], rd_B [0:1], rs1_A [0:1], rs1_B [0:1], rs2_A [0:1], rs2_B [0:1];
  logic [2:0]  funct3_A [0:1], funct3_B [0:1];
  logic [6:0]  funct7_A [0:1], funct7_B [0:1];
  logic [31:0] imm_A [0:1], imm_B [0:1];
  logic [7:0]  ctrls_A [0:1], ctrls_B [0:1];

  int n_vec = 0;
  int n_bad = 0;
  bit en = 1'b0;

  bit [7:0] ctrl_tab [bit [6:0]];
  byte      fmt_tab  [bit [6:0]];
  bit [6:0] legal_ops [9] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17};

  decode_unit dut (
    .clk(clk), .rst_n(rst_n), .instr_A(instr_A), .instr_B(instr_B),
    .opcode_A(opcode_A), .opcode_B(opcode_B),
    .rd_A(rd_A), .rd_B(rd_B), .funct3_A(funct3_A), .funct3_B(funct3_B),
    .rs1_A(rs1_A), .rs1_B(rs1_B), .rs2_A(rs2_A), .rs2_B(rs2_B),
    .funct7_A(funct7_A), .funct7_B(funct7_B), .imm_A(imm_A), .imm_B(imm_B),
    .ctrls_A(ctrls_A), .ctrls_B(ctrls_B)
  );

  // 10-unit clock, rising edges at 5, 15, 25, ...
  always #5 clk = ~clk;

  // Reference immediate by instruction format, built with integer arithmetic.
  function automatic logic [31:0] model_imm(input logic [31:0] i);
    int unsigned u;
    int s;
    byte f;
    u = i;
    s = $signed(i);
    f = fmt_tab.exists(i[6:0]) ? fmt_tab[i[6:0]] : "X";
    case (f)
      "I": return 32'(s >>> 20);
      "S": return 32'((s >>> 25) * 32 + int'((u >> 7) % 32));
      "B": return 32'(((u >> 8) % 16) * 2 + ((u >> 25) % 64) * 32
                      + ((u >> 7) % 2) * 2048 - (u >> 31) * 4096);
      "J": return 32'(((u >> 21) % 1024) * 2 + ((u >> 20) % 2) * 2048
                      + ((u >> 12) % 256) * 4096 - (u >> 31) * (1 << 20));
      "U": return 32'((u >> 12) * 4096);
      default: return 32'd0;
    endcase
  endfunction

  // Full expected bundle {funct7, rs2, rs1, funct3, rd, imm, ctrls}.
  function automatic logic [64:0] model(input logic [31:0] i);
    int unsigned u;
    logic [7:0] c;
    u = i;
    c = ctrl_tab.exists(i[6:0]) ? ctrl_tab[i[6:0]] : 8'h80;
    return {7'(u >> 25), 5'((u >> 20) % 32), 5'((u >> 15) % 32), 3'((u >> 12) % 8),
            5'((u >> 7) % 32), model_imm(i), c};
  endfunction

  task automatic cmp(input string nm, input logic [64:0] act, input logic [64:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Expected issue-stage contents: cleared asynchronously, loaded on each edge.
  logic [64:0] exp1_a = '0;
  logic [64:0] exp1_b = '0;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp1_a = '0;
      exp1_b = '0;
    end else begin
      exp1_a = model(instr_A);
      exp1_b = model(instr_B);
    end
  end

  // Checks every output of both lanes and both stages once per cycle.
  always @(negedge clk) begin
    if (en) begin
      cmp("opcode_A", 65'(opcode_A), 65'(instr_A[6:0]));
      cmp("opcode_B", 65'(opcode_B), 65'(instr_B[6:0]));
      cmp("lane_A[0]", {funct7_A[0], rs2_A[0], rs1_A[0], funct3_A[0], rd_A[0], imm_A[0], ctrls_A[0]},
          model(instr_A));
      cmp("lane_B[0]", {funct7_B[0], rs2_B[0], rs1_B[0], funct3_B[0], rd_B[0], imm_B[0], ctrls_B[0]},
          model(instr_B));
      cmp("lane_A[1]", {funct7_A[1], rs2_A[1], rs1_A[1], funct3_A[1], rd_A[1], imm_A[1], ctrls_A[1]},
          exp1_a);
      cmp("lane_B[1]", {funct7_B[1], rs2_B[1], rs1_B[1], funct3_B[1], rd_B[1], imm_B[1], ctrls_B[1]},
          exp1_b);
    end
  end

  // Drive both lanes shortly after a rising edge, then settle.
  task automatic apply(input logic [31:0] a, input logic [31:0] b);
    @(posedge clk);
    #2;
    instr_A = a;
    instr_B = b;
    #1;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] t;
    int unsigned r;
    r = $urandom_range(0, 9);
    t = $urandom();
    if (r == 0) t = '0;
    else if (r > 2) t[6:0] = legal_ops[$urandom_range(0, 8)];
    return t;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish, got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    ctrl_tab[7'h33] = 8'h01; fmt_tab[7'h33] = "R";
    ctrl_tab[7'h13] = 8'h03; fmt_tab[7'h13] = "I";
    ctrl_tab[7'h03] = 8'h17; fmt_tab[7'h03] = "I";
    ctrl_tab[7'h67] = 8'h43; fmt_tab[7'h67] = "I";
    ctrl_tab[7'h23] = 8'h0A; fmt_tab[7'h23] = "S";
    ctrl_tab[7'h63] = 8'h20; fmt_tab[7'h63] = "B";
    ctrl_tab[7'h37] = 8'h03; fmt_tab[7'h37] = "U";
    ctrl_tab[7'h17] = 8'h03; fmt_tab[7'h17] = "U";
    ctrl_tab[7'h6F] = 8'h41; fmt_tab[7'h6F] = "J";
    en = 1'b1;

    // Held in reset with valid inputs: [1] must stay a bubble.
    apply(32'h00500093, 32'h0020A423);
    @(posedge clk); #1;
    cmp("reset ctrls_A[1]", 65'(ctrls_A[1]), 65'h00);
    cmp("reset imm_B[1]", 65'(imm_B[1]), 65'h0);
    @(posedge clk); #3;
    rst_n = 1'b1;

    // addi x1,x0,5 / sw x2,8(x1)
    apply(32'h00500093, 32'h0020A423);
    cmp("addi opcode", 65'(opcode_A), 65'h13);
    cmp("addi rd", 65'(rd_A[0]), 65'd1);
    cmp("addi imm", 65'(imm_A[0]), 65'h5);
    cmp("addi ctrls", 65'(ctrls_A[0]), 65'h03);
    cmp("model addi", model(32'h00500093), {7'h0, 5'd5, 5'd0, 3'd0, 5'd1, 32'h5, 8'h03});
    cmp("sw rs1", 65'(rs1_B[0]), 65'd1);
    cmp("sw rs2", 65'(rs2_B[0]), 65'd2);
    cmp("sw funct3", 65'(funct3_B[0]), 65'd2);
    cmp("sw imm", 65'(imm_B[0]), 65'h8);
    cmp("sw ctrls", 65'(ctrls_B[0]), 65'h0A);
    @(posedge clk); #1;
    cmp("addi imm[1]", 65'(imm_A[1]), 65'h5);
    cmp("addi ctrls[1]", 65'(ctrls_A[1]), 65'h03);

    // beq x0,x0,-4 / lui x5,0x12345
    apply(32'hFE000EE3, 32'h123452B7);
    cmp("beq imm", 65'(imm_A[0]), 65'hFFFFFFFC);
    cmp("beq ctrls", 65'(ctrls_A[0]), 65'h20);
    cmp("model beq imm", 65'(model_imm(32'hFE000EE3)), 65'hFFFFFFFC);
    cmp("lui rd", 65'(rd_B[0]), 65'd5);
    cmp("lui imm", 65'(imm_B[0]), 65'h12345000);
    cmp("lui ctrls", 65'(ctrls_B[0]), 65'h03);

    // All-zero instruction is illegal
    apply(32'h0, 32'h0);
    cmp("zero opcode", 65'(opcode_A), 65'h00);
    cmp("zero ctrls_A", 65'(ctrls_A[0]), 65'h80);
    cmp("zero ctrls_B", 65'(ctrls_B[0]), 65'h80);
    cmp("zero imm", 65'(imm_A[0]), 65'h0);

    // jal x1,8 / nop
    apply(32'h008000EF, 32'h00000013);
    cmp("jal imm", 65'(imm_A[0]), 65'h8);
    cmp("jal ctrls", 65'(ctrls_A[0]), 65'h41);
    cmp("model jal imm", 65'(model_imm(32'h008000EF)), 65'h8);
    cmp("nop ctrls", 65'(ctrls_B[0]), 65'h03);
    cmp("nop imm", 65'(imm_B[0]), 65'h0);

    // Low bits != 2'b11 on an otherwise legal opcode
    apply(32'h00500091, 32'h00000033);
    cmp("bad low bits ctrls", 65'(ctrls_A[0]), 65'h80);
    cmp("bad low bits imm", 65'(imm_A[0]), 65'h0);
    cmp("R-type ctrls", 65'(ctrls_B[0]), 65'h01);

    // Randomized stream, checked every cycle by the compare process
    for (int k = 0; k < 400; k++) apply(rand_instr(), rand_instr());

    // Mid-cycle asynchronous reset after two valid cycles
    apply(32'h00500093, 32'h0020A423);
    apply(32'hFE000EE3, 32'h123452B7);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    cmp("async rst ctrls_A[1]", 65'(ctrls_A[1]), 65'h00);
    cmp("async rst imm_A[1]", 65'(imm_A[1]), 65'h0);
    cmp("async rst rd_B[1]", 65'(rd_B[1]), 65'h0);
    cmp("async rst ctrls_B[1]", 65'(ctrls_B[1]), 65'h00);
    cmp("async rst ctrls_A[0]", 65'(ctrls_A[0]), 65'h20);
    cmp("async rst imm_B[0]", 65'(imm_B[0]), 65'h12345000);
    @(posedge clk); #3;
    rst_n = 1'b1;
    @(posedge clk); #1;
    cmp("reload ctrls_A[1]", 65'(ctrls_A[1]), 65'h20);
    cmp("reload imm_B[1]", 65'(imm_B[1]), 65'h12345000);

    for (int k = 0; k < 50; k++) apply(rand_instr(), rand_instr());

    @(posedge clk);
    @(negedge clk);
    #1;
    en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/decode_unit.md
# decode_unit

Dual-lane RV32I instruction decoder for the two-wide front end. It splits each of two fetched 32-bit instructions (lanes A and B) into register indices, function fields, a sign-extended immediate and an 8-bit control vector. Each field is produced twice:

- index [0] is the combinational decode of the current instruction.
- index [1] is that decode registered one clock later, for the issue stage.

It sits between fetch and register-read/issue.

## Interface
Parameters: none.

Clock and reset are one clock with an asynchronous, active-low reset.

- clk  in  1  rising-edge clock for the [1] stage
- rst_n  in  1  asynchronous active-low reset
- instr_A, instr_B  in  32  instruction word, lane A / lane B
- opcode_A, opcode_B  out  7  instr[6:0], combinational
- rd_X[0:1]  out  5 each  instr[11:7]
- funct3_X[0:1]  out  3 each  instr[14:12]
- rs1_X[0:1]  out  5 each  instr[19:15]
- rs2_X[0:1]  out  5 each  instr[24:20]
- funct7_X[0:1]  out  7 each  instr[31:25]
- imm_X[0:1]  out  32 each  sign-extended immediate
- ctrls_X[0:1]  out  8 each  control vector

X is A or B. In each array, [0] is combinational and [1] is registered.

## Operation
- The two lanes are fully independent and identical. There is no cross-lane hazard logic.
- Field outputs are raw bit slices and are always driven, whatever the format. The ctrls bits indicate which fields are meaningful.
- Immediate by opcode:
  - I-type (0010011, 0000011, 1100111): {20{i[31]}, i[31:20]}
  - S-type (0100011): {20{i[31]}, i[31:25], i[11:7]}
  - B-type (1100011): {19{i[31]}, i[31], i[7], i[30:25], i[11:8], 1'b0}
  - U-type (0110111, 0010111): {i[31:12], 12'b0}
  - J-type (1101111): {11{i[31]}, i[31], i[19:12], i[20], i[30:21], 1'b0}
  - R-type (0110011) and illegal: 0
- ctrls bit map:
  - [0] reg_write
  - [1] alu_src_imm
  - [2] mem_read
  - [3] mem_write
  - [4] mem_to_reg
  - [5] branch
  - [6] jump
  - [7] illegal
- ctrls value per opcode:
  - R-type: 0x01
  - I-ALU: 0x03
  - LOAD: 0x17
  - STORE: 0x0A
  - BRANCH: 0x20
  - JAL: 0x41
  - JALR: 0x43
  - LUI: 0x03
  - AUIPC: 0x03
- Illegal: any other opcode, or instr[1:0] != 2'b11. Illegal gives ctrls = 0x80 and imm = 0; the other fields remain raw slices.
- All-zero instruction: decodes as illegal, ctrls 0x80.
- funct3 and funct7 are not validated. Sub-op legality is checked downstream by the ALU decode.

## Timing
- [0] outputs and opcode_X are purely combinational from instr_X, with no latency.
- [1] outputs equal the [0] values sampled at the previous rising clk edge, a latency of exactly 1 cycle.
- Reset:
  - While rst_n is low, every [1] output is 0, including ctrls 0x00, which acts as a bubble/NOP.
  - Reset takes effect immediately and asynchronously, including in the middle of a cycle.
  - [0] outputs and opcode are unaffected by reset.
- First rising edge after rst_n is released: [1] captures the current [0] values.
- There is no enable or stall. The [1] stage updates on every edge.

## Test plan
- Lane A 0x00500093 (addi x1,x0,5) -> opcode 0x13, rd 1, rs1 0, funct3 0, imm 0x00000005, ctrls 0x03. The same values appear on [1] one edge later.
- Lane B 0x0020A423 (sw x2,8(x1)) -> rs1 1, rs2 2, funct3 2, imm 0x00000008, ctrls 0x0A.
- Lane A 0xFE000EE3 (beq x0,x0,-4) and, in the same cycle, lane B 0x123452B7 (lui x5,0x12345):
  - A: imm 0xFFFFFFFC, ctrls 0x20
  - B: rd 5, imm 0x12345000, ctrls 0x03
  - Lanes are independent.
- Both lanes 0x00000000 -> opcode 0x00, ctrls[0] 0x80, imm 0.
- Lane A 0x008000EF (jal x1,8) -> imm 0x00000008, ctrls 0x41. Lane B 0x00000013 (nop) -> ctrls 0x03, imm 0.
- Load valid instructions and clock twice, then pull rst_n low mid-cycle:
  - All [1] outputs go to 0 immediately, without waiting for an edge.
  - [0] outputs are unchanged.
  - After rst_n is released, the next edge reloads [1].
